// File: rtl/mul_operand_sequencer_if.sv
// Handshake and multiplier-bus bundle for the operand sequencer.
// slave = sequencer side, master = upstream/multiplier/result-sink side.
interface mul_operand_sequencer_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] mul_data;
    logic          mul_start;
    logic          mul_done;
    logic [DW-1:0] mul_product;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_product;
    logic          out_err;
    logic          busy;

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_product, out_ready,
        output in_ready, mul_data, mul_start, out_valid, out_product, out_err, busy
    );

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_product, out_ready,
        input  in_ready, mul_data, mul_start, out_valid, out_product, out_err, busy
    );
endinterface

// File: rtl/mul_operand_sequencer.sv
// Operand-pair FIFO feeding a repeated-addition multiplier: drives A then B on the
// shared bus with start, waits for done (with watchdog), returns the product.
module mul_operand_sequencer #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 70000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mul_operand_sequencer_if.slave       bus
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]    FULL   = (AW+1)'(FIFO_DEPTH);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    typedef enum logic [2:0] {IDLE, START, LDA, LDB, WAIT, DRAIN, RESP} state_t;

    pair_t         mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    pair_t         head;

    state_t        state;
    pair_t         job;
    logic [WDW-1:0] wd;
    logic [DW-1:0] mul_data_q, product_q;
    logic          mul_start_q, out_valid_q, err_q;

    assign bus.in_ready = (count != FULL);
    assign push = bus.in_valid && bus.in_ready;
    // Hold off a new job until the multiplier has dropped done from the last one.
    assign pop  = (state == IDLE) && (count != '0) && !bus.mul_done;
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            job         <= '0;
            wd          <= '0;
            mul_data_q  <= '0;
            mul_start_q <= 1'b0;
            product_q   <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    job       <= head;
                    product_q <= '0;
                    err_q     <= 1'b0;
                    if (head.a == '0 || head.b == '0) begin
                        state       <= RESP;
                        out_valid_q <= 1'b1;
                    end else begin
                        state       <= START;
                        mul_start_q <= 1'b1;
                        mul_data_q  <= head.a;
                    end
                end
                START: begin
                    state      <= LDA;
                    mul_data_q <= job.a;
                end
                LDA: begin
                    state      <= LDB;
                    mul_data_q <= job.b;
                end
                LDB: begin
                    state <= WAIT;
                    wd    <= '0;
                end
                WAIT: begin
                    // done is checked first so it wins over a same-cycle timeout
                    if (bus.mul_done) begin
                        product_q   <= bus.mul_product;
                        err_q       <= 1'b0;
                        state       <= DRAIN;
                        mul_start_q <= 1'b0;
                        mul_data_q  <= '0;
                        wd          <= '0;
                    end else if (wd == WD_MAX) begin
                        product_q   <= '0;
                        err_q       <= 1'b1;
                        state       <= DRAIN;
                        mul_start_q <= 1'b0;
                        mul_data_q  <= '0;
                        wd          <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DRAIN: begin
                    state       <= RESP;
                    out_valid_q <= 1'b1;
                end
                RESP: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mul_data    = mul_data_q;
    assign bus.mul_start   = mul_start_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = product_q;
    assign bus.out_err     = err_q;
    assign bus.busy        = (state != IDLE) || (count != '0);
endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Scoreboard bench for mul_operand_sequencer with a behavioural repeated-addition multiplier.
module tb_mul_operand_sequencer;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_operand_sequencer_if #(.DW(DW)) bus ();

    mul_operand_sequencer #(.DW(DW), .FIFO_DEPTH(4), .TIMEOUT(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed { logic [DW-1:0] a; logic [DW-1:0] b; } op_t;
    typedef struct packed { logic [DW-1:0] p; logic e; } res_t;

    op_t  exp_op [$];
    res_t exp_res[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", name);
    endfunction

    // Multiplier model: latches A on the first start cycle, B on the third,
    // raises done after mdl_delay start cycles and holds it until start drops.
    int            mdl_delay = 6;
    bit            mdl_stuck = 1'b0;
    logic          m_busy;
    logic [DW-1:0] m_a, m_b;
    int            m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy          <= 1'b0;
            m_cnt           <= 0;
            m_a             <= '0;
            m_b             <= '0;
            bus.mul_done    <= 1'b0;
            bus.mul_product <= '0;
        end else if (bus.mul_start) begin
            if (!m_busy) begin
                m_busy <= 1'b1;
                m_a    <= bus.mul_data;
                m_cnt  <= 1;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 2) m_b <= bus.mul_data;
                if (m_cnt == mdl_delay && !mdl_stuck) begin
                    bus.mul_done    <= 1'b1;
                    bus.mul_product <= DW'(m_a * m_b);
                end
            end
        end else begin
            m_busy       <= 1'b0;
            bus.mul_done <= 1'b0;
        end
    end

    // Monitor: operand order on the bus, done->valid latency, result scoreboard.
    int   cyc = 0;
    int   start_cnt = 0;
    initial begin
        int   sidx = 0;
        int   done_cyc = 0;
        bit   pend = 1'b0;
        logic prev_done = 1'b0;
        logic prev_ov = 1'b0;
        op_t  op;
        res_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                sidx = 0; pend = 1'b0; prev_done = 1'b0; prev_ov = 1'b0;
            end else begin
                if (bus.mul_start) begin
                    start_cnt++;
                    if (sidx == 0 || sidx == 2) begin
                        if (exp_op.size() == 0) fail("unexpected_start");
                        else begin
                            op = exp_op[0];
                            if (sidx == 0) chk("mul_data_A", 32'(bus.mul_data), 32'(op.a));
                            else begin
                                chk("mul_data_B", 32'(bus.mul_data), 32'(op.b));
                                exp_op.pop_front();
                            end
                        end
                    end
                    sidx++;
                end else sidx = 0;
                if (bus.mul_done && !prev_done) begin done_cyc = cyc; pend = 1'b1; end
                if (bus.out_valid && !prev_ov && pend) begin
                    chk("done_to_valid_latency", 32'(cyc - done_cyc), 32'd2);
                    pend = 1'b0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_res.size() == 0) fail("extra_result");
                    else begin
                        r = exp_res.pop_front();
                        chk("out_product", 32'(bus.out_product), 32'(r.p));
                        chk("out_err", 32'(bus.out_err), 32'(r.e));
                    end
                end
                prev_done = bus.mul_done;
                prev_ov   = bus.out_valid;
            end
        end
    end

    // Drives at posedge+1; returns once the pair is accepted, then queues expectations.
    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] p, input logic e);
        int n = 0;
        bit ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        while (!ok && n < 500) begin
            @(negedge clk); ok = bus.in_ready;
            @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b0;
        if (!ok) fail("push_accept");
        else begin
            exp_res.push_back('{p: p, e: e});
            if (a != '0 && b != '0) exp_op.push_back('{a: a, b: b});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_res.size() != 0 || bus.busy) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) fail("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) fail("wait_out_valid");
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_in_ready"},    32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"},   32'(bus.out_valid), 32'd0);
        chk({tag, "_mul_start"},   32'(bus.mul_start), 32'd0);
        chk({tag, "_mul_data"},    32'(bus.mul_data), 32'd0);
        chk({tag, "_out_product"}, 32'(bus.out_product), 32'd0);
        chk({tag, "_out_err"},     32'(bus.out_err), 32'd0);
        chk({tag, "_busy"},        32'(bus.busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b1;

        // basic job; A and B order plus latency checked by the monitor
        push(16'd17, 16'd5, 16'd85, 1'b0);
        wait_idle();

        // zero operands bypass the multiplier
        s0 = start_cnt;
        push(16'd0, 16'd9, 16'd0, 1'b0);
        push(16'd9, 16'd0, 16'd0, 1'b0);
        wait_idle();
        chk("bypass_no_start", 32'(start_cnt - s0), 32'd0);

        // backpressure: job0 parks in RESP, then four more fill the FIFO
        bus.out_ready = 1'b0;
        push(16'd2, 16'd3, 16'd6, 1'b0);
        wait_valid();
        push(16'd4, 16'd5, 16'd20, 1'b0);
        push(16'd10, 16'd10, 16'd100, 1'b0);
        push(16'd0, 16'd3, 16'd0, 1'b0);
        push(16'd7, 16'd8, 16'd56, 1'b0);
        @(negedge clk);
        chk("in_ready_full", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_a = 16'd11; bus.in_b = 16'd3;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("in_ready_still_full", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        push(16'd11, 16'd3, 16'd33, 1'b0);
        wait_idle();

        // stuck multiplier: 3 load cycles + 20 WAIT cycles, then error result
        mdl_stuck = 1'b1;
        s0 = start_cnt;
        push(16'd7, 16'd7, 16'd0, 1'b1);
        wait_idle();
        chk("timeout_start_cycles", 32'(start_cnt - s0), 32'd23);
        mdl_stuck = 1'b0;
        push(16'd6, 16'd7, 16'd42, 1'b0);
        wait_idle();

        // reset in the middle of WAIT
        mdl_delay = 15;
        push(16'd300, 16'd200, 16'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1 chk("start_in_wait", 32'(bus.mul_start), 32'd1);
        rst_n = 1'b0;
        exp_op.delete();
        exp_res.delete();
        #2 chk_reset_outputs("midjob_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        mdl_delay = 6;
        push(16'd3, 16'd4, 16'd12, 1'b0);
        wait_idle();

        // truncation to DW bits
        push(16'd65535, 16'd2, 16'd65534, 1'b0);
        wait_idle();
        chk("leftover_results", 32'(exp_res.size()), 32'd0);
        chk("leftover_operands", 32'(exp_op.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
